// File: rtl/fb_rect_writer.sv
// Rectangle fill engine: takes one clipped rectangle command and emits one
// frame-buffer pixel write per cycle in raster order, then a one-cycle done pulse.
module fb_rect_writer #(
  parameter int FB_W = 800,
  parameter int FB_H = 525
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [9:0] cmd_x0,
  input  logic [9:0] cmd_y0,
  input  logic [9:0] cmd_w,
  input  logic [9:0] cmd_h,
  input  logic [2:0] cmd_color,
  output logic       fb_we,
  output logic [9:0] fb_x,
  output logic [9:0] fb_y,
  output logic [2:0] fb_wdata,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  localparam logic [10:0] W_LIM = 11'(FB_W);
  localparam logic [10:0] H_LIM = 11'(FB_H);

  state_t      state, state_nxt;
  logic [9:0]  x_org;
  logic [10:0] x_end, y_end;
  logic [10:0] x_sum, y_sum;
  logic        accept, empty, row_last, col_last;

  // Bounds are formed one bit wider so x0+w never wraps before clipping.
  assign x_sum    = {1'b0, cmd_x0} + {1'b0, cmd_w};
  assign y_sum    = {1'b0, cmd_y0} + {1'b0, cmd_h};
  assign accept   = cmd_valid && (state == IDLE);
  assign empty    = (cmd_w == '0) || (cmd_h == '0) ||
                    ({1'b0, cmd_x0} >= W_LIM) || ({1'b0, cmd_y0} >= H_LIM);
  assign row_last = ({1'b0, fb_x} + 11'd1) == x_end;
  assign col_last = ({1'b0, fb_y} + 11'd1) == y_end;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    fb_we     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = empty ? DONE : FILL;
      end
      FILL: begin
        fb_we = 1'b1;
        if (row_last && col_last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The write address doubles as the raster cursor; it holds after the last pixel.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fb_x     <= '0;
      fb_y     <= '0;
      fb_wdata <= '0;
      x_org    <= '0;
      x_end    <= '0;
      y_end    <= '0;
    end else if (accept && !empty) begin
      fb_x     <= cmd_x0;
      fb_y     <= cmd_y0;
      fb_wdata <= cmd_color;
      x_org    <= cmd_x0;
      x_end    <= (x_sum > W_LIM) ? W_LIM : x_sum;
      y_end    <= (y_sum > H_LIM) ? H_LIM : y_sum;
    end else if (state == FILL) begin
      if (!row_last) begin
        fb_x <= fb_x + 10'd1;
      end else if (!col_last) begin
        fb_x <= x_org;
        fb_y <= fb_y + 10'd1;
      end
    end
  end

endmodule

// File: tb/tb_fb_rect_writer.sv
// Randomized bench for fb_rect_writer: every command's write stream is compared
// cycle by cycle against a pixel list built from plain clipped-rectangle loops.
module tb_fb_rect_writer;
  // Reduced height keeps the full-frame fill well inside the cycle budget.
  localparam int FB_W = 800;
  localparam int FB_H = 48;

  logic       clock = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready;
  logic [9:0] cmd_x0, cmd_y0, cmd_w, cmd_h;
  logic [2:0] cmd_color;
  logic       fb_we, done;
  logic [9:0] fb_x, fb_y;
  logic [2:0] fb_wdata;

  int n_cmp = 0;
  int n_err = 0;
  int nx0, ny0, nw, nh, nc;
  int cx, cy, cw, ch, cc;
  bit chain;

  always #5 clock = ~clock;

  fb_rect_writer #(.FB_W(FB_W), .FB_H(FB_H)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_color(cmd_color),
    .fb_we(fb_we), .fb_x(fb_x), .fb_y(fb_y), .fb_wdata(fb_wdata),
    .done(done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    cmd_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  function automatic int pick(input int lim);
    if ($urandom_range(0, 3) == 0) return lim - int'($urandom_range(0, 6));
    return int'($urandom_range(0, lim + 20));
  endfunction

  // When chain is set, the staged nx*/ny*/.. command is presented right after
  // acceptance with cmd_valid left high.
  task automatic run_cmd(input int x0, input int y0, input int w, input int h,
                         input int c, input bit chain_next);
    int qx[$];
    int qy[$];
    int e0;
    for (int y = y0; y < y0 + h && y < FB_H; y++)
      for (int x = x0; x < x0 + w && x < FB_W; x++) begin
        qx.push_back(x);
        qy.push_back(y);
      end
    if (!cmd_valid) begin
      @(negedge clock);
      cmd_x0 = 10'(x0); cmd_y0 = 10'(y0); cmd_w = 10'(w); cmd_h = 10'(h);
      cmd_color = 3'(c);
      cmd_valid = 1'b1;
    end
    chk("ready", cmd_ready, 1);
    @(posedge clock);
    #1;
    if (chain_next) begin
      cmd_x0 = 10'(nx0); cmd_y0 = 10'(ny0); cmd_w = 10'(nw); cmd_h = 10'(nh);
      cmd_color = 3'(nc);
    end else begin
      cmd_valid = 1'b0;
      cmd_x0 = 10'($urandom); cmd_y0 = 10'($urandom);
      cmd_w = 10'($urandom);  cmd_h = 10'($urandom);
      cmd_color = 3'($urandom);
    end
    e0 = n_err;
    foreach (qx[i]) begin
      @(negedge clock);
      chk("pix", {fb_we, fb_x, fb_y, fb_wdata},
          {1'b1, 10'(qx[i]), 10'(qy[i]), 3'(c)});
      if (n_err != e0) break;
    end
    if (n_err != e0) begin
      do_reset();
      return;
    end
    @(negedge clock);
    chk("done", {done, fb_we, cmd_ready}, 3'b100);
    @(negedge clock);
    chk("idle", {done, fb_we, cmd_ready}, 3'b001);
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_x0 = '0; cmd_y0 = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
    #12;
    chk("rst_state", {cmd_ready, fb_we, done, fb_x, fb_y, fb_wdata},
        {1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 3'd0});
    @(negedge clock);
    reset = 1'b0;

    // Directed: basic fill, corner clip, empty variants, 11-bit overflow.
    run_cmd(10, 20, 3, 2, 5, 0);
    run_cmd(FB_W - 2, FB_H - 1, 5, 4, 3, 0);
    run_cmd(5, 5, 0, 4, 7, 0);
    run_cmd(5, 5, 4, 0, 7, 0);
    run_cmd(FB_W, 3, 4, 4, 7, 0);
    run_cmd(3, FB_H, 2, 2, 1, 0);
    run_cmd(1023, 1023, 1023, 1023, 6, 0);
    run_cmd(798, 0, 1023, 2, 2, 0);
    run_cmd(10, FB_H - 2, 3, 9, 4, 0);

    // Back-to-back with cmd_valid held high across both commands.
    nx0 = 30; ny0 = 5; nw = 2; nh = 2; nc = 4;
    run_cmd(100, 7, 3, 1, 1, 1);
    run_cmd(30, 5, 2, 2, 4, 0);

    // Reset in the middle of a 100x100 fill after 37 writes.
    @(negedge clock);
    cmd_x0 = 10'd50; cmd_y0 = 10'd10; cmd_w = 10'd100; cmd_h = 10'd100;
    cmd_color = 3'd2;
    cmd_valid = 1'b1;
    chk("ready_big", cmd_ready, 1);
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    for (int i = 0; i < 37; i++) begin
      @(negedge clock);
      chk("big_pix", {fb_we, fb_x, fb_y, fb_wdata},
          {1'b1, 10'(50 + i), 10'd10, 3'd2});
    end
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
    chk("rst_abort", {cmd_ready, fb_we, done, fb_x, fb_y, fb_wdata},
        {1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 3'd0});
    repeat (2) begin
      @(negedge clock);
      chk("rst_hold", {done, fb_we, cmd_ready}, 3'b001);
    end
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      chk("post_rst", {done, fb_we, cmd_ready}, 3'b001);
    end
    run_cmd(7, 8, 1, 1, 3, 0);

    // Random commands biased toward the frame edges, some chained.
    cx = pick(FB_W); cy = pick(FB_H);
    cw = int'($urandom_range(0, 10)); ch = int'($urandom_range(0, 5));
    cc = int'($urandom_range(0, 7));
    repeat (40) begin
      chain = ($urandom_range(0, 2) == 0);
      nx0 = pick(FB_W); ny0 = pick(FB_H);
      nw = int'($urandom_range(0, 10)); nh = int'($urandom_range(0, 5));
      nc = int'($urandom_range(0, 7));
      run_cmd(cx, cy, cw, ch, cc, chain);
      cx = nx0; cy = ny0; cw = nw; ch = nh; cc = nc;
    end
    if (cmd_valid) run_cmd(cx, cy, cw, ch, cc, 0);

    // Full-frame fill from an oversized command.
    run_cmd(0, 0, 1023, 1023, 7, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
